// File: rtl/fsm_tx.sv
// Transmit side of the 16-bit word link: sends one 32-bit float as two
// valid/ack half-words and reports special operands, drops and timeouts on err.
module fsm_tx #(
  parameter bit HI_FIRST = 1'b1,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        R_I,
  input  logic [31:0] dataIn,
  output logic        busy,
  output logic [15:0] dataOut,
  output logic        r_o,
  input  logic        ack_i,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      dout_q, dout_d;
  logic [1:0]       err_q, err_d;

  function automatic logic [15:0] first_half(input logic [31:0] w);
    return HI_FIRST ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [15:0] second_half(input logic [31:0] w);
    return HI_FIRST ? w[15:0] : w[31:16];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Only the half still to be sent needs holding; the first goes straight to dout.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (R_I) begin
          state_d = SEND_A;
          hold_d  = second_half(dataIn);
          cnt_d   = '0;
          dout_d  = first_half(dataIn);
          err_d   = (dataIn[30:23] == 8'hFF) ? 2'b01 : 2'b00;
        end
      end
      SEND_A, SEND_B: begin
        if (ack_i) begin
          // An ack in the last allowed cycle beats the timeout.
          cnt_d = '0;
          if (state_q == SEND_A) begin
            state_d = SEND_B;
            dout_d  = hold_q;
          end else begin
            state_d = IDLE;
          end
          if (R_I) err_d = 2'b10;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 2'b11;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (R_I) err_d = 2'b10;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    r_o     = (state_q != IDLE);
    dataOut = dout_q;
    err     = err_q;
  end

endmodule
